// File: rtl/traffic_phase_sched.sv
// Demand-actuated four-way phase scheduler: latches car/left/ped requests per
// approach, arbitrates NS vs EW with alternation, and sequences tick-timed phases.
module traffic_phase_sched #(
   parameter int TICK_DIV  = 4,
   parameter int ALLRED_T  = 1,
   parameter int LEFT_T    = 5,
   parameter int GREEN_MIN = 5,
   parameter int GREEN_MAX = 10,
   parameter int YELLOW_T  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_ns_car,
   input  logic       req_ns_left,
   input  logic       req_ns_ped,
   input  logic       req_ew_car,
   input  logic       req_ew_left,
   input  logic       req_ew_ped,
   input  logic       emg,
   output logic [7:0] lights,
   output logic       walk_ns,
   output logic       walk_ew,
   output logic [2:0] phase,
   output logic [5:0] pending
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TMAX = max2(max2(max2(ALLRED_T, LEFT_T), max2(GREEN_MIN, GREEN_MAX)), YELLOW_T);
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      ALLRED    = 3'd0,
      NS_LEFT   = 3'd1,
      NS_GREEN  = 3'd2,
      NS_YELLOW = 3'd3,
      EW_LEFT   = 3'd4,
      EW_GREEN  = 3'd5,
      EW_YELLOW = 3'd6,
      EMG       = 3'd7
   } state_t;

   state_t          r_state;
   state_t          w_state_nx;
   logic [PW-1:0]   r_presc;
   logic [TW-1:0]   r_tcnt;
   logic            r_last_ew;
   logic [5:0]      r_pend;
   logic            r_walk_en_ns;
   logic            r_walk_en_ew;

   logic            w_tick;
   logic [31:0]     w_done;
   logic            w_ns_dem;
   logic            w_ew_dem;
   logic            w_serve_ew;
   logic            w_entry;
   logic [5:0]      w_set;
   logic [5:0]      w_clr;

   // w_done is the tick count including the tick firing on this edge
   assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
   assign w_done     = 32'(r_tcnt) + 32'd1;
   assign w_ns_dem   = |r_pend[5:3];
   assign w_ew_dem   = |r_pend[2:0];
   assign w_serve_ew = w_ew_dem && (!w_ns_dem || !r_last_ew);
   assign w_entry    = (w_state_nx != r_state);

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ALLRED: begin
            if (w_tick && w_done >= 32'(ALLRED_T) && (w_ns_dem || w_ew_dem)) begin
               if (w_serve_ew) w_state_nx = r_pend[2] ? EW_LEFT : EW_GREEN;
               else            w_state_nx = r_pend[5] ? NS_LEFT : NS_GREEN;
            end
         end
         NS_LEFT:   if (w_tick && w_done >= 32'(LEFT_T)) w_state_nx = NS_GREEN;
         EW_LEFT:   if (w_tick && w_done >= 32'(LEFT_T)) w_state_nx = EW_GREEN;
         NS_GREEN: begin
            if (w_tick && ((w_done >= 32'(GREEN_MIN) && w_ew_dem) || w_done >= 32'(GREEN_MAX)))
               w_state_nx = NS_YELLOW;
         end
         EW_GREEN: begin
            if (w_tick && ((w_done >= 32'(GREEN_MIN) && w_ns_dem) || w_done >= 32'(GREEN_MAX)))
               w_state_nx = EW_YELLOW;
         end
         NS_YELLOW: if (w_tick && w_done >= 32'(YELLOW_T)) w_state_nx = ALLRED;
         EW_YELLOW: if (w_tick && w_done >= 32'(YELLOW_T)) w_state_nx = ALLRED;
         EMG:       if (!emg) w_state_nx = ALLRED;
         default:   w_state_nx = ALLRED;
      endcase
      if (emg) w_state_nx = EMG;
   end

   always_comb begin
      w_set = {req_ns_left, req_ns_car, req_ns_ped, req_ew_left, req_ew_car, req_ew_ped};
      w_clr = '0;
      if (w_entry) begin
         w_clr[5]   = (w_state_nx == NS_LEFT);
         w_clr[4:3] = {2{w_state_nx == NS_GREEN}};
         w_clr[2]   = (w_state_nx == EW_LEFT);
         w_clr[1:0] = {2{w_state_nx == EW_GREEN}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ALLRED;
         r_last_ew    <= 1'b1;
         r_pend       <= '0;
         r_walk_en_ns <= 1'b0;
         r_walk_en_ew <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_pend  <= (r_pend & ~w_clr) | w_set;
         if (r_state == NS_YELLOW && w_state_nx == ALLRED) r_last_ew <= 1'b0;
         if (r_state == EW_YELLOW && w_state_nx == ALLRED) r_last_ew <= 1'b1;
         if (w_entry && w_state_nx == NS_GREEN) r_walk_en_ns <= r_pend[3];
         if (w_entry && w_state_nx == EW_GREEN) r_walk_en_ew <= r_pend[0];
      end
   end

   // Idle ALLRED saturates at ALLRED_T so every later tick re-arbitrates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
         r_tcnt  <= '0;
      end else if (w_entry || r_state == EMG) begin
         r_presc <= '0;
         r_tcnt  <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
         if (r_state == ALLRED && w_done > 32'(ALLRED_T)) r_tcnt <= TW'(ALLRED_T);
         else                                             r_tcnt <= r_tcnt + TW'(1);
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   always_comb begin
      lights = 8'b0001_0001;
      case (r_state)
         NS_LEFT:   lights = 8'b1001_0001;
         NS_GREEN:  lights = 8'b0100_0001;
         NS_YELLOW: lights = 8'b0010_0001;
         EW_LEFT:   lights = 8'b0001_1001;
         EW_GREEN:  lights = 8'b0001_0100;
         EW_YELLOW: lights = 8'b0001_0010;
         default:   lights = 8'b0001_0001;
      endcase
   end

   assign phase   = r_state;
   assign pending = r_pend;
   assign walk_ns = (r_state == NS_GREEN) && r_walk_en_ns && (32'(r_tcnt) < 32'(GREEN_MIN));
   assign walk_ew = (r_state == EW_GREEN) && r_walk_en_ew && (32'(r_tcnt) < 32'(GREEN_MIN));

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for traffic_phase_sched with default parameters (1 tick = 4 clk).
// Cycle n means the falling edge after the n-th rising edge since reset release.
module tb_traffic_phase_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_ns_car = 1'b0, req_ns_left = 1'b0, req_ns_ped = 1'b0;
   logic       req_ew_car = 1'b0, req_ew_left = 1'b0, req_ew_ped = 1'b0;
   logic       emg = 1'b0;
   logic [7:0] lights;
   logic       walk_ns, walk_ew;
   logic [2:0] phase;
   logic [5:0] pending;

   int n_checks = 0;
   int n_errors = 0;
   int cyc_now  = 0;

   traffic_phase_sched #(
      .TICK_DIV(4), .ALLRED_T(1), .LEFT_T(5), .GREEN_MIN(5), .GREEN_MAX(10), .YELLOW_T(3)
   ) dut (
      .clk(clk), .rst(rst),
      .req_ns_car(req_ns_car), .req_ns_left(req_ns_left), .req_ns_ped(req_ns_ped),
      .req_ew_car(req_ew_car), .req_ew_left(req_ew_left), .req_ew_ped(req_ew_ped),
      .emg(emg), .lights(lights), .walk_ns(walk_ns), .walk_ew(walk_ew),
      .phase(phase), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc_now, obs, exp);
      end
   endtask

   task automatic run_to(input int n);
      while (cyc_now < n) begin
         @(negedge clk);
         cyc_now++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cyc_now = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // asynchronous reset before any clock edge
      #1 rst = 1'b1;
      #1;
      chk("rst_lights",  32'(lights),  32'h11);
      chk("rst_phase",   32'(phase),   32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_walk",    32'({walk_ns, walk_ew}), 32'd0);
      @(negedge clk);

      // single NS request: GREEN_MAX bound, idle ALLRED, same-tick request latency
      do_reset();
      req_ns_car = 1'b1; run_to(1); req_ns_car = 1'b0;
      chk("s1_pend_set",  32'(pending), 32'h10);
      chk("s1_allred",    32'(phase),   32'd0);
      run_to(3);  chk("s1_allred_end", 32'(phase), 32'd0);
      run_to(4);
      chk("s1_green_ph",  32'(phase),   32'd2);
      chk("s1_green_li",  32'(lights),  32'h41);
      chk("s1_pend_clr",  32'(pending), 32'h00);
      chk("s1_no_walk",   32'(walk_ns), 32'd0);
      run_to(43); chk("s1_green_last", 32'(phase), 32'd2);
      run_to(44);
      chk("s1_yel_ph",    32'(phase),   32'd3);
      chk("s1_yel_li",    32'(lights),  32'h21);
      run_to(55); chk("s1_yel_last", 32'(phase), 32'd3);
      run_to(56);
      chk("s1_allred2",   32'(phase),   32'd0);
      chk("s1_allred2_li",32'(lights),  32'h11);
      run_to(119); chk("s1_idle", 32'(phase), 32'd0);
      req_ew_car = 1'b1; run_to(120); req_ew_car = 1'b0;
      chk("s1_late_req_pend", 32'(pending), 32'h02);
      chk("s1_late_req_hold", 32'(phase),   32'd0);
      run_to(123); chk("s1_late_wait", 32'(phase), 32'd0);
      run_to(124);
      chk("s1_ew_green",  32'(phase),   32'd5);
      chk("s1_ew_li",     32'(lights),  32'h14);
      chk("s1_ew_walk",   32'(walk_ew), 32'd0);

      // NS left + ped with EW car demand
      do_reset();
      req_ns_left = 1'b1; req_ns_ped = 1'b1; req_ew_car = 1'b1;
      run_to(1);
      req_ns_left = 1'b0; req_ns_ped = 1'b0; req_ew_car = 1'b0;
      chk("s2_pend",      32'(pending), 32'h2A);
      run_to(4);
      chk("s2_left_ph",   32'(phase),   32'd1);
      chk("s2_left_li",   32'(lights),  32'h91);
      chk("s2_left_clr",  32'(pending), 32'h0A);
      run_to(23); chk("s2_left_last", 32'(phase), 32'd1);
      run_to(24);
      chk("s2_green_ph",  32'(phase),   32'd2);
      chk("s2_walk_on",   32'(walk_ns), 32'd1);
      chk("s2_pend_g",    32'(pending), 32'h02);
      run_to(43);
      chk("s2_walk_last", 32'(walk_ns), 32'd1);
      chk("s2_green_last",32'(phase),   32'd2);
      run_to(44);
      chk("s2_yel_min",   32'(phase),   32'd3);
      chk("s2_walk_off",  32'(walk_ns), 32'd0);
      run_to(56); chk("s2_allred", 32'(phase), 32'd0);
      run_to(60);
      chk("s2_ew_green",  32'(phase),   32'd5);
      chk("s2_ew_pend",   32'(pending), 32'h00);

      // tie arbitration, same-edge set/clear, emergency mid-green
      do_reset();
      req_ns_car = 1'b1; req_ew_car = 1'b1; run_to(1);
      req_ns_car = 1'b0; req_ew_car = 1'b0;
      chk("s3_pend",      32'(pending), 32'h12);
      run_to(4);
      chk("s3_ns_first",  32'(phase),   32'd2);
      chk("s3_pend_ns",   32'(pending), 32'h02);
      run_to(24); chk("s3_ns_yel", 32'(phase), 32'd3);
      run_to(36); chk("s3_allred", 32'(phase), 32'd0);
      req_ew_car = 1'b1;
      run_to(40);
      chk("s3_ew_second", 32'(phase),   32'd5);
      chk("s3_set_wins",  32'(pending), 32'h02);
      req_ew_car = 1'b0; req_ns_car = 1'b1; run_to(41); req_ns_car = 1'b0;
      chk("s3_pend_both", 32'(pending), 32'h12);
      run_to(59); chk("s3_ew_green_last", 32'(phase), 32'd5);
      run_to(60);
      chk("s3_ew_yel",    32'(phase),   32'd6);
      chk("s3_ew_yel_li", 32'(lights),  32'h12);
      run_to(72); chk("s3_allred2", 32'(phase), 32'd0);
      run_to(76);
      chk("s3_ns_again",  32'(phase),   32'd2);
      chk("s3_pend_ew",   32'(pending), 32'h02);
      run_to(88);
      emg = 1'b1;
      run_to(89);
      chk("s4_emg_ph",    32'(phase),   32'd7);
      chk("s4_emg_li",    32'(lights),  32'h11);
      chk("s4_emg_walk",  32'({walk_ns, walk_ew}), 32'd0);
      run_to(91); req_ew_ped = 1'b1; run_to(92); req_ew_ped = 1'b0;
      chk("s4_emg_latch", 32'(pending), 32'h03);
      run_to(98);
      chk("s4_emg_hold",  32'(phase),   32'd7);
      emg = 1'b0;
      run_to(99);  chk("s4_release", 32'(phase), 32'd0);
      run_to(102); chk("s4_allred_end", 32'(phase), 32'd0);
      run_to(103);
      chk("s4_ew_served", 32'(phase),   32'd5);
      chk("s4_walk_ew",   32'(walk_ew), 32'd1);
      chk("s4_pend_clr",  32'(pending), 32'h00);

      // asynchronous reset during NS_YELLOW
      do_reset();
      req_ns_car = 1'b1; run_to(1); req_ns_car = 1'b0;
      run_to(44); chk("s5_yel", 32'(phase), 32'd3);
      req_ew_ped = 1'b1; run_to(45); req_ew_ped = 1'b0;
      chk("s5_pend", 32'(pending), 32'h01);
      #2 rst = 1'b1;
      #1;
      chk("s5_rst_phase",   32'(phase),   32'd0);
      chk("s5_rst_lights",  32'(lights),  32'h11);
      chk("s5_rst_pending", 32'(pending), 32'h00);
      chk("s5_rst_walk",    32'({walk_ns, walk_ew}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/traffic_phase_sched.md
# traffic_phase_sched

Demand-actuated phase scheduler for the four-way intersection light set. It latches car, left-turn and pedestrian requests from both approaches and an emergency pre-empt. It arbitrates between the North-South and East-West approaches and sequences the phases with second-resolution timing. It drives the same 8-bit `lights` encoding used by the fixed-cycle light block, so it can replace that block at the top level. It also drives pedestrian WALK outputs.

## Interface
- `TICK_DIV`, 4: clk cycles per timing tick (one "second"); ≥1.
- `ALLRED_T`, 1: all-red clearance, in ticks.
- `LEFT_T`, 5: protected-left duration, in ticks.
- `GREEN_MIN`, 5: minimum green, in ticks.
- `GREEN_MAX`, 10: maximum green, in ticks; must be ≥ `GREEN_MIN`.
- `YELLOW_T`, 3: yellow duration, in ticks.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_ns_car`, `req_ns_left`, `req_ns_ped`  in  1 each  North-South demand pulses/levels.
- `req_ew_car`, `req_ew_left`, `req_ew_ped`  in  1 each  East-West demand pulses/levels.
- `emg`  in  1  emergency pre-empt, level.
- `lights`  out  8  light encoding:
  - [7] NS left, [6] NS green, [5] NS yellow, [4] NS red.
  - [3] EW left, [2] EW green, [1] EW yellow, [0] EW red.
- `walk_ns`, `walk_ew`  out  1 each  pedestrian WALK per approach.
- `phase`  out  3  current state code.
- `pending`  out  6  latched requests, in the order {ns_left, ns_car, ns_ped, ew_left, ew_car, ew_ped}.

## Operation
- **States and `phase` codes:**
  - ALLRED=0, NS_LEFT=1, NS_GREEN=2, NS_YELLOW=3, EW_LEFT=4, EW_GREEN=5, EW_YELLOW=6, EMG=7.
- **`lights` decode (combinational from state):**
  - ALLRED/EMG 8'b0001_0001.
  - NS_LEFT 8'b1001_0001, NS_GREEN 8'b0100_0001, NS_YELLOW 8'b0010_0001.
  - EW_LEFT 8'b0001_1001, EW_GREEN 8'b0001_0100, EW_YELLOW 8'b0001_0010.
- **Request latches:**
  - Each `req_*` high on a clock edge sets its `pending` bit.
  - `ns_left` clears on entry to NS_LEFT; `ns_car` and `ns_ped` clear on entry to NS_GREEN. EW bits clear the same way.
  - If set and clear fall on the same edge, set wins and the bit stays 1.
  - NS demand = any NS pending bit; EW demand likewise.
- **Timing base:**
  - A prescaler counts 0..`TICK_DIV`-1 and emits a tick on the last count.
  - The tick counter increments on each tick.
  - Both counters clear on every state change, so a state lasting N ticks lasts exactly N·`TICK_DIV` cycles.
- **Transitions:** evaluated on tick edges, except EMG.
  - **ALLRED:**
    - After `ALLRED_T` ticks, select a direction with demand. If both have demand, pick the direction opposite `last_dir`.
    - Go to `<dir>_LEFT` if that left bit is pending, else `<dir>_GREEN`.
    - With no demand, remain in ALLRED and re-evaluate on each subsequent tick.
  - **`<dir>_LEFT`:** go to `<dir>_GREEN` after `LEFT_T` ticks. The green entry clears car and ped.
  - **`<dir>_GREEN`:**
    - Go to `<dir>_YELLOW` when the tick count is ≥ `GREEN_MIN` and the opposing direction has demand.
    - Also go to `<dir>_YELLOW` when the count reaches `GREEN_MAX`, regardless of demand.
  - **`<dir>_YELLOW`:** after `YELLOW_T` ticks, go to ALLRED and set `last_dir` := dir.
- **Emergency:**
  - `emg`=1 forces EMG on the next edge from any state and clears both counters.
  - While in EMG, requests continue to latch.
  - When `emg` falls, EMG goes to ALLRED on the next edge and normal arbitration resumes.
  - `last_dir` is unchanged by EMG.
- **WALK:**
  - At NS_GREEN entry, `walk_en_ns` := `pending.ns_ped` as sampled before the clear.
  - `walk_ns` = NS_GREEN && `walk_en_ns` && tick count < `GREEN_MIN`. EW is symmetric.
  - WALK is forced 0 in every other state, including EMG.

## Timing
- **Reset values while `rst`=1 and after it falls:**
  - state ALLRED, `lights`=8'b0001_0001, `phase`=0, `pending`=0, walk=0.
  - Counters 0, `last_dir`=EW, so NS is served first on a tie.
- **Reset mid-phase:** `rst` asynchronously forces the reset values at once, including discarding pending requests.
- **Latency:**
  - Request to `pending` bit: 1 cycle.
  - `emg` rise to `lights`=all-red: 1 cycle.
  - Every other transition lands exactly on a tick edge.
- **Counter widths:**
  - Prescaler is clog2(`TICK_DIV`) bits, minimum 1.
  - Tick counter is wide enough for `GREEN_MAX`; it must not wrap within any state.
  - Idle ALLRED dwell saturates the tick counter at `ALLRED_T`.
- **Simultaneous events:**
  - `emg` overrides any same-edge tick transition.
  - A request arriving on the tick edge that evaluates ALLRED is visible only on the next tick.

## Test plan
Defaults are used throughout; 1 tick = 4 cycles.
- **Single NS request:** reset, then pulse `req_ns_car` at cycle 0, no other demand.
  - ALLRED 4 cycles, then NS_GREEN for 40 cycles (forced by `GREEN_MAX`).
  - Then NS_YELLOW for 12 cycles, then ALLRED; `lights` values follow the decode table.
- **Left plus ped, NS:** pulse `req_ns_left`, `req_ns_ped`, and `req_ew_car` during ALLRED.
  - NS_LEFT for 20 cycles, then NS_GREEN.
  - `walk_ns`=1 for the first 20 cycles of NS_GREEN; yellow after exactly `GREEN_MIN` (20 cycles).
  - Then ALLRED, then EW_GREEN.
- **Tie arbitration:** NS and EW car requests both pending from reset.
  - NS is served first; after the NS cycle, EW is served.
  - With both re-requested, NS is served next (alternation).
- **Emergency mid-green:** assert `emg` for 10 cycles at NS_GREEN tick 3.
  - `lights`=8'b0001_0001 the next cycle and `phase`=7.
  - After release: ALLRED, then EW first if EW demand is pending, because `last_dir` is still EW and the tie-break prefers NS only on a tie.
- **Same-edge set/clear:** hold `req_ew_car` high across EW_GREEN entry.
  - `pending.ew_car` stays 1.
- **Async reset:** assert `rst` mid-NS_YELLOW.
  - All outputs return to reset values without waiting for a clock edge.
